// File: rtl/apb_irq_master_pkg.sv
// Shared types and register offsets for the APB event-unit fetch master.
// Offsets mirror the event unit's word-indexed register map.
package apb_irq_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   localparam int REG_IDX_ENABLE  = 0;
   localparam int REG_IDX_PENDING = 1;
   localparam int REG_IDX_ACK     = 2;

   localparam int ADDR_W = 12;

   localparam logic [ADDR_W-1:0] OFFS_ENABLE  = ADDR_W'(REG_IDX_ENABLE * 4);
   localparam logic [ADDR_W-1:0] OFFS_PENDING = ADDR_W'(REG_IDX_PENDING * 4);
   localparam logic [ADDR_W-1:0] OFFS_ACK     = ADDR_W'(REG_IDX_ACK * 4);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic              is_fetch;
   } req_t;

endpackage

// File: rtl/apb_irq_fetch_master.sv
// APB initiator that drains the event unit's ACK register while irq is high
// and forwards single config accesses from the core-side request port.
//
// state  | meaning
// IDLE   | no transfer; arbitrate config request vs. ACK fetch
// SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS | APB access phase, waiting for PREADY or timeout
module apb_irq_fetch_master
   import apb_irq_master_pkg::*;
#(
   parameter int                        APB_ADDR_WIDTH = 12,
   parameter logic [APB_ADDR_WIDTH-1:0] ACK_ADDR       = APB_ADDR_WIDTH'(OFFS_ACK),
   parameter int                        TIMEOUT_CYCLES = 16
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      fetch_en_i,
   input  logic                      irq_i,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR,
   input  logic                      cfg_valid_i,
   output logic                      cfg_ready_o,
   input  logic                      cfg_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] cfg_addr_i,
   input  logic [31:0]               cfg_wdata_i,
   output logic                      cfg_rsp_valid_o,
   output logic [31:0]               cfg_rsp_rdata_o,
   output logic                      cfg_rsp_err_o,
   output logic                      evt_valid_o,
   output logic [31:0]               evt_id_o,
   input  logic                      evt_ready_i,
   output logic                      err_o
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      r_state;
   state_e      w_state_nxt;
   req_t        r_req;
   logic [7:0]  r_cnt;
   logic        r_evt_valid;
   logic [31:0] r_evt_id;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic        r_err;

   logic w_take_cfg;
   logic w_take_fetch;
   logic w_done_ok;
   logic w_timeout;
   logic w_xfer_end;
   logic w_xfer_err;

   // Config wins over fetch; a full event buffer blocks fetching.
   assign w_take_cfg   = (r_state == ST_IDLE) && cfg_valid_i;
   assign w_take_fetch = (r_state == ST_IDLE) && !cfg_valid_i && fetch_en_i
                         && irq_i && !r_evt_valid;
   assign w_done_ok    = (r_state == ST_ACCESS) && PREADY;
   assign w_timeout    = (r_state == ST_ACCESS) && !PREADY && (r_cnt == CNT_LAST);
   assign w_xfer_end   = w_done_ok || w_timeout;
   assign w_xfer_err   = (w_done_ok && PSLVERR) || w_timeout;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_take_cfg || w_take_fetch) w_state_nxt = ST_SETUP;
         ST_SETUP:  w_state_nxt = ST_ACCESS;
         ST_ACCESS: if (w_xfer_end) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_req <= '0;
      end else if (w_take_cfg) begin
         r_req.write    <= cfg_write_i;
         r_req.addr     <= ADDR_W'(cfg_addr_i);
         r_req.wdata    <= cfg_wdata_i;
         r_req.is_fetch <= 1'b0;
      end else if (w_take_fetch) begin
         r_req.write    <= 1'b0;
         r_req.addr     <= ADDR_W'(ACK_ADDR);
         r_req.wdata    <= '0;
         r_req.is_fetch <= 1'b1;
      end
   end

   // Counts ACCESS cycles without PREADY; cleared outside ACCESS.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)                             r_cnt <= '0;
      else if (r_state != ST_ACCESS)          r_cnt <= '0;
      else if (!PREADY)                       r_cnt <= r_cnt + 8'd1;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_rsp_valid <= w_xfer_end && !r_req.is_fetch;
         r_rsp_err   <= w_xfer_err && !r_req.is_fetch;
         r_rsp_rdata <= (w_done_ok && !r_req.is_fetch && !r_req.write) ? PRDATA : 32'd0;
         r_err       <= w_xfer_err;
      end
   end

   // A zero ACK value means nothing was pending; it is dropped.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_evt_valid <= 1'b0;
         r_evt_id    <= '0;
      end else if (w_done_ok && r_req.is_fetch && !PSLVERR && (PRDATA != 32'd0)) begin
         r_evt_valid <= 1'b1;
         r_evt_id    <= PRDATA;
      end else if (r_evt_valid && evt_ready_i) begin
         r_evt_valid <= 1'b0;
      end
   end

   assign PSEL            = (r_state != ST_IDLE);
   assign PENABLE         = (r_state == ST_ACCESS);
   assign PADDR           = APB_ADDR_WIDTH'(r_req.addr);
   assign PWRITE          = r_req.write;
   assign PWDATA          = r_req.wdata;
   assign cfg_ready_o     = w_take_cfg;
   assign cfg_rsp_valid_o = r_rsp_valid;
   assign cfg_rsp_rdata_o = r_rsp_rdata;
   assign cfg_rsp_err_o   = r_rsp_err;
   assign evt_valid_o     = r_evt_valid;
   assign evt_id_o        = r_evt_id;
   assign err_o           = r_err;

endmodule

// File: tb/tb_apb_irq_fetch_master.sv
// Scoreboard bench for apb_irq_fetch_master: expected config responses and
// event IDs are queued at stimulus time and checked when the DUT emits them.
module tb_apb_irq_fetch_master;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        chk_rdata;
   } cfg_exp_t;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        fetch_en_i;
   logic        irq_i;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        cfg_valid_i;
   logic        cfg_ready_o;
   logic        cfg_write_i;
   logic [11:0] cfg_addr_i;
   logic [31:0] cfg_wdata_i;
   logic        cfg_rsp_valid_o;
   logic [31:0] cfg_rsp_rdata_o;
   logic        cfg_rsp_err_o;
   logic        evt_valid_o;
   logic [31:0] evt_id_o;
   logic        evt_ready_i;
   logic        err_o;

   int          n_vec = 0;
   int          n_err = 0;
   cfg_exp_t    cfg_q[$];
   logic [31:0] evt_q[$];

   apb_irq_fetch_master dut (
      .HCLK(HCLK), .HRESET(HRESET), .fetch_en_i(fetch_en_i), .irq_i(irq_i),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
      .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_write_i(cfg_write_i), .cfg_addr_i(cfg_addr_i),
      .cfg_wdata_i(cfg_wdata_i), .cfg_rsp_valid_o(cfg_rsp_valid_o),
      .cfg_rsp_rdata_o(cfg_rsp_rdata_o), .cfg_rsp_err_o(cfg_rsp_err_o),
      .evt_valid_o(evt_valid_o), .evt_id_o(evt_id_o),
      .evt_ready_i(evt_ready_i), .err_o(err_o)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic cfg_req(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
      cfg_valid_i = 1'b1;
      cfg_write_i = wr;
      cfg_addr_i  = addr;
      cfg_wdata_i = wdata;
      #1;
      chk("cfg_ready", 32'(cfg_ready_o), 32'd1);
      tick();
      cfg_valid_i = 1'b0;
   endtask

   always @(negedge HCLK) begin : monitor
      cfg_exp_t ce;
      logic [31:0] ee;
      if (!HRESET) begin
         if (cfg_rsp_valid_o) begin
            if (cfg_q.size() == 0) chk("cfg_rsp_unexpected", 32'd1, 32'd0);
            else begin
               ce = cfg_q.pop_front();
               chk("cfg_rsp_err", 32'(cfg_rsp_err_o), 32'(ce.err));
               if (ce.chk_rdata) chk("cfg_rsp_rdata", cfg_rsp_rdata_o, ce.rdata);
            end
         end
         if (evt_valid_o && evt_ready_i) begin
            if (evt_q.size() == 0) chk("evt_unexpected", 32'd1, 32'd0);
            else begin
               ee = evt_q.pop_front();
               chk("evt_id", evt_id_o, ee);
            end
         end
      end
   end

   initial begin
      int n;
      HRESET = 1'b1; fetch_en_i = 1'b0; irq_i = 1'b0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      cfg_valid_i = 1'b0; cfg_write_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
      evt_ready_i = 1'b0;
      repeat (3) tick();
      chk("rst_psel", 32'(PSEL), 32'd0);
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_paddr", 32'(PADDR), 32'd0);
      chk("rst_rsp_valid", 32'(cfg_rsp_valid_o), 32'd0);
      chk("rst_evt_valid", 32'(evt_valid_o), 32'd0);
      chk("rst_evt_id", evt_id_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      HRESET = 1'b0;
      tick();

      // config write: rdata must be 0 even though PRDATA is non-zero
      PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
      cfg_q.push_back('{32'd0, 1'b0, 1'b1});
      cfg_req(1'b1, 12'h000, 32'h0000_00FF);
      chk("wr_setup_psel", 32'(PSEL), 32'd1);
      chk("wr_setup_penable", 32'(PENABLE), 32'd0);
      chk("wr_setup_pwrite", 32'(PWRITE), 32'd1);
      chk("wr_setup_paddr", 32'(PADDR), 32'h000);
      chk("wr_setup_pwdata", PWDATA, 32'h0000_00FF);
      tick();
      chk("wr_access_penable", 32'(PENABLE), 32'd1);
      tick();
      chk("wr_idle_psel", 32'(PSEL), 32'd0);
      chk("wr_err", 32'(err_o), 32'd0);

      // config read, then config read with PSLVERR
      PRDATA = 32'h0000_1234;
      cfg_q.push_back('{32'h0000_1234, 1'b0, 1'b1});
      cfg_req(1'b0, 12'h004, 32'd0);
      tick(); tick();
      PSLVERR = 1'b1; PRDATA = 32'h0000_005A;
      cfg_q.push_back('{32'h0000_005A, 1'b1, 1'b1});
      cfg_req(1'b0, 12'h004, 32'd0);
      tick(); tick();
      chk("slverr_err_pulse", 32'(err_o), 32'd1);
      PSLVERR = 1'b0;
      tick();
      chk("slverr_err_clear", 32'(err_o), 32'd0);

      // fetch with backpressure
      PRDATA = 32'd5; evt_ready_i = 1'b0; fetch_en_i = 1'b1; irq_i = 1'b1;
      evt_q.push_back(32'd5);
      tick();
      chk("fetch_setup_psel", 32'(PSEL), 32'd1);
      chk("fetch_setup_penable", 32'(PENABLE), 32'd0);
      chk("fetch_paddr", 32'(PADDR), 32'h008);
      chk("fetch_pwrite", 32'(PWRITE), 32'd0);
      tick();
      chk("fetch_access_penable", 32'(PENABLE), 32'd1);
      tick();
      chk("fetch_lat_valid", 32'(evt_valid_o), 32'd1);
      chk("fetch_lat_id", evt_id_o, 32'd5);
      chk("fetch_lat_psel", 32'(PSEL), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_psel", 32'(PSEL), 32'd0);
         chk("bp_valid", 32'(evt_valid_o), 32'd1);
         chk("bp_id", evt_id_o, 32'd5);
      end
      PRDATA = 32'd7; evt_ready_i = 1'b1;
      evt_q.push_back(32'd7);
      tick();
      chk("pop_valid_clear", 32'(evt_valid_o), 32'd0);
      tick();
      chk("refetch_setup", 32'(PSEL & ~PENABLE), 32'd1);
      tick(); tick();
      chk("refetch_valid", 32'(evt_valid_o), 32'd1);
      chk("refetch_id", evt_id_o, 32'd7);
      irq_i = 1'b0;
      tick();
      chk("refetch_popped", 32'(evt_valid_o), 32'd0);
      tick();
      chk("irq_low_idle", 32'(PSEL), 32'd0);

      // empty ACK: keeps re-fetching, never produces an event
      PRDATA = 32'd0; irq_i = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (PSEL && !PENABLE) n++;
         chk("empty_no_evt", 32'(evt_valid_o), 32'd0);
      end
      chk("empty_refetch_count", 32'(n), 32'd4);
      irq_i = 1'b0;
      tick(); tick();

      // fetch disabled: irq alone must not start a transfer
      fetch_en_i = 1'b0; irq_i = 1'b1;
      repeat (3) tick();
      chk("fetch_dis_psel", 32'(PSEL), 32'd0);
      irq_i = 1'b0;

      // timeout on a config read
      PREADY = 1'b0;
      cfg_q.push_back('{32'd0, 1'b1, 1'b0});
      cfg_req(1'b0, 12'h004, 32'd0);
      n = 0;
      for (int i = 0; i < 40 && PSEL; i++) begin
         if (PENABLE) n++;
         tick();
      end
      chk("timeout_psel_drop", 32'(PSEL), 32'd0);
      chk("timeout_access_cycles", 32'(n), 32'd16);
      chk("timeout_err_pulse", 32'(err_o), 32'd1);
      tick();
      chk("timeout_err_clear", 32'(err_o), 32'd0);
      PREADY = 1'b1;

      // priority: config before fetch, one IDLE cycle between
      PRDATA = 32'd9; fetch_en_i = 1'b1; irq_i = 1'b1; evt_ready_i = 1'b1;
      cfg_q.push_back('{32'd9, 1'b0, 1'b1});
      evt_q.push_back(32'd9);
      cfg_req(1'b0, 12'h00C, 32'd0);
      chk("prio_cfg_first", 32'(PADDR), 32'h00C);
      tick(); tick();
      chk("prio_idle_gap", 32'(PSEL), 32'd0);
      tick();
      chk("prio_fetch_setup", 32'(PSEL & ~PENABLE), 32'd1);
      chk("prio_fetch_paddr", 32'(PADDR), 32'h008);
      tick(); tick();
      chk("prio_evt_valid", 32'(evt_valid_o), 32'd1);
      irq_i = 1'b0;
      tick(); tick();

      // asynchronous reset in the middle of ACCESS
      PREADY = 1'b0;
      cfg_req(1'b1, 12'h000, 32'd1);
      tick(); tick();
      chk("rstmid_in_access", 32'(PENABLE), 32'd1);
      HRESET = 1'b1;
      #1;
      chk("rstmid_psel_async", 32'(PSEL), 32'd0);
      chk("rstmid_penable_async", 32'(PENABLE), 32'd0);
      tick();
      HRESET = 1'b0; PREADY = 1'b1;
      repeat (3) tick();
      chk("rstmid_idle", 32'(PSEL), 32'd0);
      chk("rstmid_evt_valid", 32'(evt_valid_o), 32'd0);
      chk("rstmid_no_rsp", 32'(cfg_rsp_valid_o), 32'd0);

      chk("cfg_q_drained", 32'(cfg_q.size()), 32'd0);
      chk("evt_q_drained", 32'(evt_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
